// File: rtl/cw_deserializer.sv
// Serial-to-parallel receive stage that assembles N-bit codewords and holds each one in a single valid/ready register.
// Define CW_DESERIALIZER_BITREV_EN to place the first received bit at cw_out[N-1] instead of cw_out[0].
module cw_deserializer #(
   parameter int N  = 42,
   parameter int CW = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_bit,
   input  logic          in_valid,
   input  logic          in_sof,
   output logic [0:N-1]  cw_out,
   output logic          cw_valid,
   input  logic          cw_ready,
   output logic          overflow,
   output logic          frame_err,
   output logic [CW-1:0] bit_cnt
);

   // The final bit never lands in sreg; it goes straight into the assembled word.
   logic [0:N-2]  sreg;
   logic [0:N-1]  word;
   logic [0:N-1]  word_o;
   logic [CW-1:0] pos;
   logic          last;

   always_comb begin
      pos  = in_sof ? '0 : bit_cnt;
      last = in_valid && (pos == CW'(N-1));
      word = {sreg, in_bit};
   end

`ifdef CW_DESERIALIZER_BITREV_EN
   always_comb begin
      word_o = '0;
      for (int i = 0; i < N; i++) word_o[i] = word[N-1-i];
   end
`else
   assign word_o = word;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg      <= '0;
         bit_cnt   <= '0;
         cw_out    <= '0;
         cw_valid  <= 1'b0;
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (in_valid) begin
            if (in_sof && bit_cnt != '0) frame_err <= 1'b1;
            if (last) begin
               bit_cnt <= '0;
            end else begin
               sreg[pos] <= in_bit;
               bit_cnt   <= pos + CW'(1);
            end
         end
         // A completing word may load whenever the slot is empty or draining this cycle.
         if (last && (!cw_valid || cw_ready)) begin
            cw_out   <= word_o;
            cw_valid <= 1'b1;
         end else begin
            if (last) overflow <= 1'b1;
            if (cw_valid && cw_ready) cw_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cw_deserializer.sv
// Scoreboard bench for cw_deserializer: expected words are queued as frames are sent and checked on each transfer.
module tb_cw_deserializer;
   localparam int N  = 42;
   localparam int CW = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_bit, in_valid, in_sof, cw_ready;
   logic [0:N-1]  cw_out;
   logic          cw_valid, overflow, frame_err;
   logic [CW-1:0] bit_cnt;

   cw_deserializer #(.N(N), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid), .in_sof(in_sof),
      .cw_out(cw_out), .cw_valid(cw_valid), .cw_ready(cw_ready), .overflow(overflow),
      .frame_err(frame_err), .bit_cnt(bit_cnt)
   );

   always #5 clk = ~clk;

   int errs = 0, checks = 0, cyc = 0;
   logic [0:N-1] sb[$];
   int xfer_cyc[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [0:N-1] expw(input logic [0:N-1] w);
      logic [0:N-1] r;
`ifdef CW_DESERIALIZER_BITREV_EN
      for (int i = 0; i < N; i++) r[N-1-i] = w[i];
`else
      r = w;
`endif
      return r;
   endfunction

   always @(posedge clk) cyc++;

   // Transfer monitor: a transfer happens on the next rising edge when valid & ready.
   always @(negedge clk) begin
      if (rst_n && cw_valid && cw_ready) begin
         if (sb.size() == 0) chk("unexpected_xfer", 64'(cw_out), 64'hDEAD);
         else chk("cw_out", 64'(cw_out), 64'(sb.pop_front()));
         xfer_cyc.push_back(cyc);
      end
   end

   task automatic send_bit(input logic b, input logic sof);
      in_bit = b; in_sof = sof; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_sof = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_frame(input logic [0:N-1] w, input bit push);
      for (int i = 0; i < N; i++) send_bit(w[i], i == 0);
      if (push) sb.push_back(expw(w));
   endtask

   task automatic do_reset();
      rst_n = 1'b0; #12; rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   logic [0:N-1] w, a, z;
   int gp, n0, c0;

   initial begin
      in_bit = 0; in_valid = 0; in_sof = 0; cw_ready = 0; rst_n = 1;
      do_reset();
      chk("rst_valid", 64'(cw_valid), 0);
      chk("rst_ovf", 64'(overflow), 0);
      chk("rst_ferr", 64'(frame_err), 0);
      chk("rst_cnt", 64'(bit_cnt), 0);
      chk("rst_out", 64'(cw_out), 0);

      // Basic all-ones frame
      cw_ready = 1;
      a = '1;
      for (int i = 0; i < N; i++) begin
         send_bit(1'b1, i == 0);
         if (i == 9) chk("cnt_mid", 64'(bit_cnt), 10);
         if (i == N-2) chk("valid_early", 64'(cw_valid), 0);
      end
      sb.push_back(expw(a));
      chk("basic_valid", 64'(cw_valid), 1);
      chk("basic_cnt", 64'(bit_cnt), 0);
      chk("basic_out", 64'(cw_out), 64'h3FF_FFFF_FFFF);
      idle(1);
      chk("basic_drop", 64'(cw_valid), 0);

      // Ordering with a 3-cycle gap
      gp = $urandom_range(5, 35);
      w = '0; w[0] = 1'b1;
      send_bit(1'b1, 1'b1);
      for (int i = 1; i < N; i++) begin
         if (i == gp)
            for (int g = 0; g < 3; g++) begin idle(1); chk("gap_hold", 64'(bit_cnt), 64'(gp)); end
         send_bit(1'b0, 1'b0);
      end
      sb.push_back(expw(w));
      idle(2);

      // Back-pressure and overflow
      cw_ready = 0;
      a = '1; z = '0;
      n0 = xfer_cyc.size();
      send_frame(a, 1'b1);
      for (int i = 0; i < N-1; i++) send_bit(1'b0, i == 0);
      chk("ovf_before", 64'(overflow), 0);
      send_bit(1'b0, 1'b0);
      chk("ovf_set", 64'(overflow), 1);
      chk("ovf_hold", 64'(cw_out), 64'(expw(a)));
      chk("ovf_valid", 64'(cw_valid), 1);
      idle(3);
      chk("ovf_sticky", 64'(overflow), 1);
      cw_ready = 1;
      idle(1);
      chk("ovf_drain", 64'(cw_valid), 0);
      idle(2);
      chk("ovf_xfers", 64'(xfer_cyc.size() - n0), 1);

      do_reset();
      chk("ovf_clear", 64'(overflow), 0);

      // Back-to-back frames
      n0 = xfer_cyc.size();
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < N; i++) w[i] = 1'($urandom_range(0, 1));
         send_frame(w, 1'b1);
      end
      idle(3);
      chk("b2b_xfers", 64'(xfer_cyc.size() - n0), 3);
      if (xfer_cyc.size() - n0 == 3) begin
         chk("b2b_gap1", 64'(xfer_cyc[n0+1] - xfer_cyc[n0]), 42);
         chk("b2b_gap2", 64'(xfer_cyc[n0+2] - xfer_cyc[n0+1]), 42);
      end
      chk("b2b_ovf", 64'(overflow), 0);

      // Resync: sof after 17 bits
      n0 = xfer_cyc.size();
      for (int i = 0; i < 17; i++) send_bit(1'b1, i == 0);
      for (int i = 0; i < N; i++) w[i] = 1'($urandom_range(0, 1));
      send_bit(w[0], 1'b1);
      chk("resync_ferr", 64'(frame_err), 1);
      chk("resync_cnt", 64'(bit_cnt), 1);
      send_bit(w[1], 1'b0);
      chk("resync_pulse", 64'(frame_err), 0);
      for (int i = 2; i < N-1; i++) send_bit(w[i], 1'b0);
      chk("resync_novalid", 64'(cw_valid), 0);
      send_bit(w[N-1], 1'b0);
      sb.push_back(expw(w));
      chk("resync_valid", 64'(cw_valid), 1);
      idle(3);
      chk("resync_xfers", 64'(xfer_cyc.size() - n0), 1);

      // Async reset mid-frame with a held word and overflow set
      cw_ready = 0;
      send_frame(a, 1'b0);
      send_frame(z, 1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
      chk("pre_rst_ovf", 64'(overflow), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(cw_valid), 0);
      chk("arst_ovf", 64'(overflow), 0);
      chk("arst_cnt", 64'(bit_cnt), 0);
      #1 rst_n = 1'b1;
      cw_ready = 1;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) w[i] = 1'($urandom_range(0, 1));
      c0 = xfer_cyc.size();
      send_frame(w, 1'b1);
      idle(3);
      chk("post_rst_xfers", 64'(xfer_cyc.size() - c0), 1);

      chk("sb_empty", 64'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/cw_deserializer.md
Name: cw_deserializer

Overview:
- Channel-side receive stage sitting directly upstream of the (42,32) burst-correcting decoder (burst length 4).
- Collects a serial bit stream into 42-bit codewords, where the first received bit becomes codeword[0].
- Presents each codeword to the decoder through a single-entry valid/ready output register.
- Reports overflow and framing faults; it never stalls the serial channel.

Parameters:
- N, 42, codeword length in bits (valid range 2..64).
- CW, 6, bit-counter width; must satisfy 2^CW >= N.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_bit  input  1  serial channel bit.
- in_valid  input  1  in_bit is valid this cycle.
- in_sof  input  1  start-of-frame marker; qualified by in_valid.
- cw_out  output  [0:N-1]  assembled codeword; cw_out[0] is the first bit received.
- cw_valid  output  1  cw_out holds an unconsumed codeword.
- cw_ready  input  1  downstream decoder/sink accepts cw_out.
- overflow  output  1  sticky; a completed word was dropped.
- frame_err  output  1  one-cycle pulse; a partial frame was discarded by in_sof.
- bit_cnt  output  [CW-1:0]  bits collected in the current frame.

Behaviour:
- Reset (async assert, sync release): shift register = 0, bit_cnt = 0, cw_out = 0, cw_valid = 0, overflow = 0, frame_err = 0.
- Reset mid-frame discards the partial frame and any held word.
- States:
  - IDLE: bit_cnt == 0.
  - COLLECT: 0 < bit_cnt < N.
  - The output register is tracked independently by cw_valid (FULL or EMPTY).
- Bit capture, on in_valid = 1:
  - The bit is written at position bit_cnt: sreg[bit_cnt] <= in_bit.
  - bit_cnt increments.
  - With in_valid = 0, nothing changes and the bit_cnt hold is unlimited.
- Frame start:
  - in_valid = 1 and in_sof = 1 forces the bit to position 0 and sets bit_cnt to 1.
  - If bit_cnt != 0 at that moment, frame_err pulses high for exactly one cycle and the partial bits are lost.
  - in_sof = 1 with in_valid = 0 is ignored.
- Completion:
  - Occurs when in_valid = 1 and the bit lands at position N-1 (including N = 2 with sof).
  - Next cycle, {sreg[0:N-2], in_bit} goes to cw_out, cw_valid is 1 and bit_cnt is 0. Latency from the last bit to cw_valid is 1 cycle.
  - bit_cnt wraps to 0; it never reaches N.
- Output handshake:
  - A transfer occurs on a cycle with cw_valid & cw_ready.
  - cw_out stays stable while cw_valid = 1 and no transfer occurs.
  - cw_valid drops the cycle after a transfer unless a new word completes in the same cycle.
- Simultaneous completion and transfer: the new word loads and cw_valid stays 1, giving back-to-back words with no bubble.
- Completion while FULL and no transfer:
  - The new word is dropped and overflow is set.
  - The held word is preserved.
  - overflow clears only on reset.
- Completion coincident with in_sof at position 0: this is not possible for N > 1. sof always restarts the frame.
- No combinational path from any input to any output; every output is registered.

Optional Feature:
- Macro: CW_DESERIALIZER_BITREV_EN.
- Defined: the first received bit is placed at cw_out[N-1] and the last at cw_out[0] (LSB-first channel). Handshake, timing and flags are unchanged.
- Undefined: the first received bit is placed at cw_out[0], as specified above.

Test Plan:
- Basic frame:
  - Stimulus: reset, then 42 bits of all-ones with sof on bit 0 and cw_ready = 1.
  - Required: cw_valid rises 1 cycle after the 42nd bit; cw_out = 42'h3FF_FFFF_FFFF; cw_valid is high for exactly 1 cycle.
- Ordering and gaps:
  - Stimulus: bit pattern 1,0,0,…,0 (41 zeros), with in_valid deasserted for 3 random cycles mid-frame.
  - Required: cw_out[0] = 1 and all other bits 0; bit_cnt holds during the gaps.
- Back-pressure and overflow:
  - Stimulus: cw_ready = 0; send two complete frames A = all-ones and B = all-zeros.
  - Required: cw_out stays A; overflow = 1 from the cycle after B completes.
  - Stimulus: then raise cw_ready.
  - Required: A transfers once; cw_valid = 0 afterwards.
- Back-to-back:
  - Stimulus: cw_ready = 1 with continuous in_valid for 3 frames.
  - Required: 3 transfers, 42 cycles apart; overflow stays 0.
- Resync:
  - Stimulus: in_sof after 17 bits of a frame.
  - Required: frame_err pulses exactly 1 cycle; bit_cnt = 1; the next 41 bits complete the word 1 cycle later, with no extra cw_valid.
- Async reset:
  - Stimulus: drop rst_n mid-frame while cw_valid = 1.
  - Required: cw_valid, overflow and bit_cnt go to 0 immediately, without waiting for a clock edge; the next frame after release decodes correctly.
